// File: rtl/router_arb_pkg.sv
// Shared types and header-field constants for the router source arbiter.
// Contents: FSM state enum, header bit positions, length limit, hdr_len().
package router_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } arb_state_e;

    localparam int MAX_LEN      = 63;
    localparam int CNT_W        = $clog2(MAX_LEN + 1);
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = HDR_ADDR_LSB + 1;
    localparam int HDR_LEN_LSB  = HDR_ADDR_MSB + 1;
    localparam int HDR_LEN_MSB  = HDR_LEN_LSB + CNT_W - 1;
    localparam int BYTE_W       = HDR_LEN_MSB + 1;

    function automatic logic [CNT_W-1:0] hdr_len(
        input logic [BYTE_W-1:0] hdr
    );
        return CNT_W'(hdr >> HDR_LEN_LSB);
    endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr.
// Ports: req (request vector), ptr (start index), gnt (one-hot), idx.
module router_rr_pick #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic [N-1:0]  rot;
    logic [PW-1:0] off;
    logic [PW:0]   sum;
    logic          hit;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            rot[k] = req[(k + int'(ptr)) % N];
        end
        off = '0;
        hit = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = PW'(k);
                hit = 1'b1;
            end
        end
        sum = {1'b0, off} + {1'b0, ptr};
        if (sum >= (PW + 1)'(N)) begin
            sum = sum - (PW + 1)'(N);
        end
        idx = sum[PW-1:0];
        gnt = hit ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/router_src_arb.sv
// Packet-level round-robin arbiter feeding the router's byte input port.
// Ports: clock/reset, src_req/valid/data/ready/grant, busy, pkt_valid,
// data_in, par_err, proto_err.
module router_src_arb
    import router_arb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int GAP_CYC = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_SRC-1:0]             src_req,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [NUM_SRC-1:0][BYTE_W-1:0] src_data,
    output logic [NUM_SRC-1:0]             src_ready,
    output logic [NUM_SRC-1:0]             src_grant,
    input  logic                           busy,
    output logic                           pkt_valid,
    output logic [BYTE_W-1:0]              data_in,
    output logic                           par_err,
    output logic                           proto_err
);

    localparam int PW = $clog2(NUM_SRC);

    arb_state_e        state;
    arb_state_e        state_n;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     gidx;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     next_ptr;
    logic [NUM_SRC-1:0] pick_oh;
    logic [CNT_W-1:0]  cnt;
    logic [BYTE_W-1:0] acc;
    logic [BYTE_W-1:0] byte_g;
    logic [3:0]        gap;
    logic              vld_g;
    logic              take;
    logic              bubble;

    router_rr_pick #(
        .N  (NUM_SRC),
        .PW (PW)
    ) u_pick (
        .req (src_req),
        .ptr (rr_ptr),
        .gnt (pick_oh),
        .idx (pick_idx)
    );

    assign byte_g   = src_data[gidx];
    assign vld_g    = src_valid[gidx];
    assign next_ptr = (gidx == PW'(NUM_SRC - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        state_n   = state;
        src_ready = '0;
        take      = 1'b0;
        bubble    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|src_req) state_n = HEADER;
            end
            HEADER: begin
                take      = vld_g & ~busy;
                src_ready = src_grant & {NUM_SRC{take}};
                if (take) begin
                    state_n = (hdr_len(byte_g) == '0) ? PARITY : PAYLOAD;
                end
            end
            PAYLOAD: begin
                src_ready = src_grant & {NUM_SRC{~busy}};
                take      = vld_g & ~busy;
                bubble    = ~vld_g & ~busy;
                if (bubble) state_n = GAP;
                else if (take && cnt == CNT_W'(1)) state_n = PARITY;
            end
            PARITY: begin
                src_ready = src_grant & {NUM_SRC{~busy}};
                take      = vld_g & ~busy;
                bubble    = ~vld_g & ~busy;
                if (take || bubble) state_n = GAP;
            end
            GAP: begin
                if (!busy && gap == 4'd1) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            src_grant <= '0;
            gidx      <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            acc       <= '0;
            gap       <= '0;
            pkt_valid <= 1'b0;
            data_in   <= '0;
            par_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_n;
            par_err   <= 1'b0;
            proto_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|src_req) begin
                        src_grant <= pick_oh;
                        gidx      <= pick_idx;
                    end
                end
                HEADER: begin
                    if (take) begin
                        data_in   <= byte_g;
                        pkt_valid <= 1'b1;
                        cnt       <= hdr_len(byte_g);
                        acc       <= byte_g;
                    end
                end
                PAYLOAD: begin
                    if (take) begin
                        data_in   <= byte_g;
                        pkt_valid <= 1'b1;
                        acc       <= acc ^ byte_g;
                        cnt       <= cnt - 1'b1;
                    end
                end
                PARITY: begin
                    if (take) begin
                        data_in   <= byte_g;
                        pkt_valid <= 1'b0;
                        par_err   <= (byte_g != acc);
                        gap       <= 4'(GAP_CYC);
                    end
                end
                GAP: begin
                    // Frozen under busy so data_in holds its last value.
                    if (!busy) begin
                        gap <= gap - 4'd1;
                        if (gap == 4'd1) begin
                            src_grant <= '0;
                            data_in   <= '0;
                            rr_ptr    <= next_ptr;
                        end
                    end
                end
                default: ;
            endcase
            // Inverted parity makes the router flag the truncated packet.
            if (bubble) begin
                pkt_valid <= 1'b0;
                data_in   <= ~acc;
                proto_err <= 1'b1;
                gap       <= 4'(GAP_CYC);
            end
        end
    end

endmodule

// File: tb/tb_router_src_arb.sv
// Self-checking bench for router_src_arb: directed scenarios plus
// randomized packets against a round-robin packet-stream model.
module tb_router_src_arb;

    localparam int N   = 3;
    localparam int GAP = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic [N-1:0]     src_req;
    logic [N-1:0]     src_valid;
    logic [N-1:0][7:0] src_data;
    logic [N-1:0]     src_ready;
    logic [N-1:0]     src_grant;
    logic             busy;
    logic             pkt_valid;
    logic [7:0]       data_in;
    logic             par_err;
    logic             proto_err;

    router_src_arb #(
        .NUM_SRC (N),
        .GAP_CYC (GAP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .src_req   (src_req),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .src_grant (src_grant),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .data_in   (data_in),
        .par_err   (par_err),
        .proto_err (proto_err)
    );

    always #5 clock = ~clock;

    logic [7:0]   mem [N][512];
    int           rd [N];
    int           wr [N];
    bit           drop [N];
    logic         busy_n;
    logic [8:0]   out_q [$];
    int           out_cyc [$];
    logic [N-1:0] gq [$];
    logic [N-1:0] rdy;
    logic [N-1:0] last_grant;
    int           n_par, n_proto, rdy_bad, cyc;
    int           vectors, miscompares;

    task automatic clear_agents();
        for (int i = 0; i < N; i++) begin
            rd[i] = 0;
            wr[i] = 0;
            drop[i] = 1'b0;
        end
        out_q.delete();
        out_cyc.delete();
        gq.delete();
        n_par = 0;
        n_proto = 0;
        rdy_bad = 0;
        busy_n = 1'b0;
        last_grant = '0;
    endtask

    task automatic push(input int s, input logic [7:0] b);
        mem[s][wr[s]] = b;
        wr[s]++;
    endtask

    task automatic push_pkt(input int s, input int len,
                            output int start);
        logic [7:0] h;
        logic [7:0] b;
        logic [7:0] par;
        start = wr[s];
        h = {len[5:0], 2'($urandom_range(0, 2))};
        par = h;
        push(s, h);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            par ^= b;
            push(s, b);
        end
        push(s, par);
    endtask

    // One clock: drive at negedge, accept at posedge, observe at negedge.
    task automatic step();
        logic [N-1:0] acc_v;
        for (int i = 0; i < N; i++) begin
            src_req[i]   = rd[i] != wr[i];
            src_valid[i] = (rd[i] != wr[i]) && !drop[i];
            src_data[i]  = (rd[i] != wr[i]) ? mem[i][rd[i]] : 8'h00;
        end
        busy = busy_n;
        #1;
        rdy = src_ready;
        acc_v = src_ready & src_valid;
        if (!$onehot0(src_ready) || !$onehot0(src_grant) ||
            (busy && src_ready != '0) ||
            ((src_ready & ~src_grant) != '0))
            rdy_bad++;
        @(posedge clock);
        for (int i = 0; i < N; i++)
            if (acc_v[i]) rd[i]++;
        @(negedge clock);
        cyc++;
        if (acc_v != '0) begin
            out_q.push_back({pkt_valid, data_in});
            out_cyc.push_back(cyc);
        end
        if (par_err) n_par++;
        if (proto_err) n_proto++;
        if (src_grant != '0 && src_grant != last_grant)
            gq.push_back(src_grant);
        last_grant = src_grant;
    endtask

    task automatic wait_out(input int n, input int budget,
                            output bit ok);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = out_q.size() >= n;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        src_req = '0;
        src_valid = '0;
        src_data = '0;
        busy = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        if ({pkt_valid, data_in, src_ready, src_grant,
             par_err, proto_err} !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want 0",
                     {pkt_valid, data_in, src_ready, src_grant,
                      par_err, proto_err});
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if ({pkt_valid, data_in, src_ready, src_grant} !== 15'h0) begin
            miscompares++;
            $display("FAIL idle_after_reset got %h want 0",
                     {pkt_valid, data_in, src_ready, src_grant});
        end
    endtask

    task automatic test_single();
        logic [7:0] pl [5];
        logic [8:0] exp;
        logic [7:0] par;
        bit ok;
        pl = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
        par = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
        pl[4] = par;
        clear_agents();
        for (int i = 0; i < 5; i++) push(0, pl[i]);
        wait_out(5, 40, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_timeout got %0d bytes want 5",
                     out_q.size());
        end
        for (int i = 0; i < 5 && i < out_q.size(); i++) begin
            exp = {i != 4, pl[i]};
            vectors++;
            if (out_q[i] !== exp) begin
                miscompares++;
                $display("FAIL single_byte%0d got %h want %h",
                         i, out_q[i], exp);
            end
        end
        vectors++;
        if (out_q.size() == 5 && out_cyc[4] - out_cyc[0] != 4) begin
            miscompares++;
            $display("FAIL single_span got %0d want 4",
                     out_cyc[4] - out_cyc[0]);
        end
        step();
        vectors++;
        if (src_grant !== 3'b001) begin
            miscompares++;
            $display("FAIL single_grant_gap got %b want 001", src_grant);
        end
        step();
        vectors++;
        if ({src_grant, data_in} !== 11'h0) begin
            miscompares++;
            $display("FAIL single_grant_drop got %b/%h want 0/0",
                     src_grant, data_in);
        end
        vectors++;
        if (n_par != 0) begin
            miscompares++;
            $display("FAIL single_par_err got %0d want 0", n_par);
        end
    endtask

    task automatic test_round_robin();
        int st;
        int total;
        int mingap;
        bit ok;
        logic [N-1:0] eg [4];
        eg = '{3'b001, 3'b010, 3'b100, 3'b001};
        pulse_reset();
        clear_agents();
        total = 0;
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < N; s++) begin
                int len = $urandom_range(0, 3);
                push_pkt(s, len, st);
                total += len + 2;
            end
        wait_out(total, 400, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rr_timeout got %0d want %0d",
                     out_q.size(), total);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= gq.size() || gq[i] !== eg[i]) begin
                miscompares++;
                $display("FAIL rr_order%0d got %b want %b", i,
                         (i < gq.size()) ? gq[i] : 3'b000, eg[i]);
            end
        end
        mingap = 1000;
        for (int i = 1; i < out_q.size(); i++)
            if (!out_q[i-1][8] && out_q[i][8] &&
                out_cyc[i] - out_cyc[i-1] - 1 < mingap)
                mingap = out_cyc[i] - out_cyc[i-1] - 1;
        vectors++;
        if (mingap < GAP) begin
            miscompares++;
            $display("FAIL rr_gap got %0d want >=%0d", mingap, GAP);
        end
        vectors++;
        if (rdy_bad != 0) begin
            miscompares++;
            $display("FAIL rr_onehot got %0d bad cycles want 0", rdy_bad);
        end
    endtask

    task automatic test_busy();
        logic [7:0] pl [6];
        logic [8:0] exp;
        bit ok;
        pl = '{8'h10, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00};
        pl[5] = pl[0] ^ pl[1] ^ pl[2] ^ pl[3] ^ pl[4];
        clear_agents();
        for (int i = 0; i < 6; i++) push(0, pl[i]);
        wait_out(2, 40, ok);
        busy_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (rdy !== 3'b000 || {pkt_valid, data_in} !== 9'h1A1) begin
                miscompares++;
                $display("FAIL busy_hold%0d got rdy=%b out=%h want 000/1a1",
                         i, rdy, {pkt_valid, data_in});
            end
        end
        busy_n = 1'b0;
        wait_out(6, 40, ok);
        vectors++;
        if (out_q.size() != 6) begin
            miscompares++;
            $display("FAIL busy_count got %0d want 6", out_q.size());
        end
        for (int i = 0; i < 6 && i < out_q.size(); i++) begin
            exp = {i != 5, pl[i]};
            vectors++;
            if (out_q[i] !== exp) begin
                miscompares++;
                $display("FAIL busy_byte%0d got %h want %h",
                         i, out_q[i], exp);
            end
        end
        repeat (4) step();
    endtask

    task automatic test_zero_len();
        bit ok;
        clear_agents();
        push(0, 8'h02);
        push(0, 8'h02);
        wait_out(2, 40, ok);
        vectors++;
        if (!ok || out_q[0] !== 9'h102 || out_q[1] !== 9'h002) begin
            miscompares++;
            $display("FAIL zlen_good got %0d bytes want 102,002",
                     out_q.size());
        end
        vectors++;
        if (ok && out_cyc[1] - out_cyc[0] != 1) begin
            miscompares++;
            $display("FAIL zlen_adjacent got %0d want 1",
                     out_cyc[1] - out_cyc[0]);
        end
        vectors++;
        if (n_par != 0) begin
            miscompares++;
            $display("FAIL zlen_no_par got %0d want 0", n_par);
        end
        push(0, 8'h02);
        push(0, 8'h03);
        wait_out(4, 40, ok);
        repeat (3) step();
        vectors++;
        if (!ok || out_q[3] !== 9'h003) begin
            miscompares++;
            $display("FAIL zlen_bad_fwd got %h want 003",
                     ok ? out_q[3] : 9'h0);
        end
        vectors++;
        if (n_par != 1) begin
            miscompares++;
            $display("FAIL zlen_par_pulse got %0d want 1", n_par);
        end
    endtask

    task automatic test_bubble();
        logic [7:0] pl [7];
        logic [7:0] run;
        bit ok;
        pl = '{8'h14, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h0B};
        run = pl[0] ^ pl[1] ^ pl[2];
        clear_agents();
        for (int i = 0; i < 7; i++) push(0, pl[i]);
        wait_out(3, 40, ok);
        drop[0] = 1'b1;
        step();
        vectors++;
        if ({pkt_valid, data_in} !== {1'b0, ~run}) begin
            miscompares++;
            $display("FAIL bubble_out got %h want %h",
                     {pkt_valid, data_in}, {1'b0, ~run});
        end
        vectors++;
        if (n_proto != 1) begin
            miscompares++;
            $display("FAIL bubble_proto got %0d want 1", n_proto);
        end
        rd[0] = wr[0];
        drop[0] = 1'b0;
        step();
        vectors++;
        if (proto_err !== 1'b0 || src_grant !== 3'b001) begin
            miscompares++;
            $display("FAIL bubble_gap got %b/%b want 0/001",
                     proto_err, src_grant);
        end
        step();
        vectors++;
        if (src_grant !== 3'b000 || out_q.size() != 3) begin
            miscompares++;
            $display("FAIL bubble_end got %b/%0d want 000/3",
                     src_grant, out_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int st;
        bit ok;
        clear_agents();
        push_pkt(0, 1, st);
        wait_out(3, 40, ok);
        step();
        step();
        push_pkt(1, 4, st);
        wait_out(5, 40, ok);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({pkt_valid, data_in, src_ready, src_grant,
             par_err, proto_err} !== 17'h0) begin
            miscompares++;
            $display("FAIL mid_reset got %h want 0",
                     {pkt_valid, data_in, src_ready, src_grant,
                      par_err, proto_err});
        end
        @(negedge clock);
        reset = 1'b0;
        clear_agents();
        push_pkt(1, 1, st);
        push_pkt(0, 1, st);
        wait_out(1, 20, ok);
        vectors++;
        if (gq.size() == 0 || gq[0] !== 3'b001) begin
            miscompares++;
            $display("FAIL mid_first_grant got %b want 001",
                     (gq.size() > 0) ? gq[0] : 3'b000);
        end
        wait_out(6, 60, ok);
        repeat (4) step();
    endtask

    task automatic test_random();
        localparam int K = 6;
        int pstart [N][K];
        int plen [N][K];
        int rem [N];
        int nxt [N];
        int p;
        int k;
        int nbad;
        logic [8:0]   exp_q [$];
        logic [N-1:0] exp_g [$];
        pulse_reset();
        clear_agents();
        for (int j = 0; j < K; j++)
            for (int s = 0; s < N; s++) begin
                int r = $urandom_range(0, 5);
                plen[s][j] = (r == 0) ? 0 : (r == 1) ? 63 :
                             $urandom_range(1, 8);
                push_pkt(s, plen[s][j], pstart[s][j]);
            end
        p = 0;
        for (int s = 0; s < N; s++) begin
            rem[s] = K;
            nxt[s] = 0;
        end
        for (int t = 0; t < N * K; t++) begin
            int s = -1;
            for (int d = 0; d < N; d++)
                if (s < 0 && rem[(p + d) % N] > 0) s = (p + d) % N;
            exp_g.push_back(N'(1) << s);
            for (int b = 0; b < plen[s][nxt[s]] + 2; b++)
                exp_q.push_back({b != plen[s][nxt[s]] + 1,
                                 mem[s][pstart[s][nxt[s]] + b]});
            nxt[s]++;
            rem[s]--;
            p = (s + 1) % N;
        end
        k = 0;
        while (out_q.size() < exp_q.size() && k < 20000) begin
            busy_n = ($urandom_range(0, 3) == 0);
            step();
            k++;
        end
        busy_n = 1'b0;
        repeat (6) step();
        vectors++;
        if (out_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count got %0d want %0d",
                     out_q.size(), exp_q.size());
        end
        nbad = 0;
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            vectors++;
            if (out_q[i] !== exp_q[i]) begin
                miscompares++;
                if (nbad++ < 8)
                    $display("FAIL rand_byte%0d got %h want %h",
                             i, out_q[i], exp_q[i]);
            end
        end
        for (int i = 0; i < exp_g.size(); i++) begin
            vectors++;
            if (i >= gq.size() || gq[i] !== exp_g[i]) begin
                miscompares++;
                if (nbad++ < 8)
                    $display("FAIL rand_grant%0d got %b want %b", i,
                             (i < gq.size()) ? gq[i] : 3'b000,
                             exp_g[i]);
            end
        end
        vectors++;
        if (n_par != 0 || n_proto != 0 || rdy_bad != 0) begin
            miscompares++;
            $display("FAIL rand_flags got par=%0d proto=%0d rdy=%0d want 0",
                     n_par, n_proto, rdy_bad);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        reset = 1'b1;
        busy = 1'b0;
        src_req = '0;
        src_valid = '0;
        src_data = '0;
        clear_agents();
        @(negedge clock);
        test_reset();
        test_single();
        test_round_robin();
        test_busy();
        test_zero_len();
        test_bubble();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
